// File: rtl/d_cache_if.sv
// Memory-side request/acknowledge bus between the data cache and main memory.
// The cache owns the request fields; memory owns the completion and read data.
interface d_cache_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/d_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache for the MEM stage.
// Stalls the pipeline through miss while a fill or write-through is in flight.
module d_cache #(
    parameter int SET_ADDR_LEN = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_req,
    input  logic        wr_req,
    input  logic [31:0] addr,
    input  logic [31:0] wr_data,
    input  logic [3:0]  wr_be,
    input  logic [2:0]  load_type,
    output logic        miss,
    output logic [31:0] rd_data,
    output logic [1:0]  addr_lo,
    output logic [2:0]  load_type_q,
    d_cache_if.master   mem
);

    localparam int SETS    = 1 << SET_ADDR_LEN;
    localparam int TAG_LEN = 30 - SET_ADDR_LEN;

    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

    state_t                    state, next_state;
    logic [SETS-1:0]           valid;
    logic [TAG_LEN-1:0]        tag_arr  [SETS];
    logic [31:0]               data_arr [SETS];

    logic [SET_ADDR_LEN-1:0]   idx;
    logic [TAG_LEN-1:0]        tag;
    logic                      hit;
    logic                      fill_en;
    logic                      write_en;

    assign idx = addr[SET_ADDR_LEN+1:2];
    assign tag = addr[31:SET_ADDR_LEN+2];
    assign hit = valid[idx] && (tag_arr[idx] == tag);

    assign fill_en  = (state == FILL)  && mem.mem_ack;
    assign write_en = (state == WRITE) && mem.mem_ack && hit;

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        next_state    = state;
        miss          = 1'b0;
        mem.mem_req   = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_addr  = '0;
        mem.mem_wdata = '0;
        mem.mem_be    = '0;
        case (state)
            IDLE: begin
                if (wr_req) begin
                    miss       = 1'b1;
                    next_state = WRITE;
                end else if (rd_req && !hit) begin
                    miss       = 1'b1;
                    next_state = FILL;
                end
            end
            FILL: begin
                miss         = 1'b1;
                mem.mem_req  = 1'b1;
                mem.mem_addr = {addr[31:2], 2'b00};
                if (mem.mem_ack) next_state = IDLE;
            end
            WRITE: begin
                miss          = 1'b1;
                mem.mem_req   = 1'b1;
                mem.mem_we    = 1'b1;
                mem.mem_addr  = {addr[31:2], 2'b00};
                mem.mem_wdata = wr_data;
                mem.mem_be    = wr_be;
                if (mem.mem_ack) next_state = DONE;
            end
            // One stall-free cycle lets the store retire exactly once.
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_ff @(posedge clk) begin
        if (rst)          valid      <= '0;
        else if (fill_en) valid[idx] <= 1'b1;
    end

    // NOTE: tag and data arrays are not reset; valid alone qualifies them,
    // which keeps the storage as plain enable flops.
    always_ff @(posedge clk) begin
        if (!rst && fill_en) begin
            tag_arr[idx]  <= tag;
            data_arr[idx] <= mem.mem_rdata;
        end else if (!rst && write_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) data_arr[idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    // WB-stage registers advance only while the pipeline is not stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data     <= '0;
            addr_lo     <= '0;
            load_type_q <= '0;
        end else if (!miss) begin
            rd_data     <= (rd_req && hit) ? data_arr[idx] : '0;
            addr_lo     <= addr[1:0];
            load_type_q <= load_type;
        end
    end

endmodule

// File: tb/tb_d_cache.sv
// Self-checking bench for d_cache: directed scenarios followed by random traffic,
// compared against a word-level cache and memory model.
module tb_d_cache;

    localparam int SAL  = 5;
    localparam int SETS = 1 << SAL;

    localparam logic [2:0] NOREGWRITE = 3'd0;
    localparam logic [2:0] LB         = 3'd1;
    localparam logic [2:0] LH         = 3'd2;
    localparam logic [2:0] LW         = 3'd3;
    localparam logic [2:0] LBU        = 3'd4;
    localparam logic [2:0] LHU        = 3'd5;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_req;
    logic        wr_req;
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic [2:0]  load_type;
    logic        miss;
    logic [31:0] rd_data;
    logic [1:0]  addr_lo;
    logic [2:0]  load_type_q;

    d_cache_if mif ();

    d_cache #(.SET_ADDR_LEN(SAL)) dut (
        .clk         (clk),
        .rst         (rst),
        .rd_req      (rd_req),
        .wr_req      (wr_req),
        .addr        (addr),
        .wr_data     (wr_data),
        .wr_be       (wr_be),
        .load_type   (load_type),
        .miss        (miss),
        .rd_data     (rd_data),
        .addr_lo     (addr_lo),
        .load_type_q (load_type_q),
        .mem         (mif)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: which word address each set holds, its data, and a
    // backing memory image keyed by word address.
    bit          m_valid [SETS];
    logic [29:0] m_word  [SETS];
    logic [31:0] m_data  [SETS];
    logic [31:0] mem_img [logic [29:0]];
    logic [31:0] exp_rd;
    logic [1:0]  exp_lo;
    logic [2:0]  exp_lt;
    logic [2:0]  lt_pool [6] = '{NOREGWRITE, LB, LH, LW, LBU, LHU};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int set_of(input logic [31:0] a);
        return int'((a >> 2) % SETS);
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        int s = set_of(a);
        return m_valid[s] && (m_word[s] == a[31:2]);
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem_img.exists(a[31:2])) return mem_img[a[31:2]];
        return {a[31:2], 2'b00} ^ 32'hA5A5_0F0F;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = 32'h0000_1000 | ($urandom_range(0, 3) << 7) | ($urandom_range(0, 3) << 2)
            | $urandom_range(0, 3);
        return a;
    endfunction

    task automatic clear_model();
        for (int s = 0; s < SETS; s++) m_valid[s] = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Trailing no-request cycle: ack is noise that must be ignored.
    task automatic idle_cycle();
        rd_req        = 1'b0;
        wr_req        = 1'b0;
        addr          = $urandom;
        load_type     = lt_pool[$urandom_range(0, 5)];
        mif.mem_ack   = 1'($urandom_range(0, 1));
        mif.mem_rdata = $urandom;
        #1;
        check("idle_miss", miss, 0);
        check("idle_mem_req", mif.mem_req, 0);
        check("idle_mem_addr", mif.mem_addr, 0);
        exp_rd = 32'h0;
        exp_lo = addr[1:0];
        exp_lt = load_type;
    endtask

    task automatic do_reset();
        next_cycle();
        rst = 1'b1; rd_req = 1'b0; wr_req = 1'b0; addr = '0; wr_data = '0; wr_be = '0;
        load_type = '0; mif.mem_ack = 1'b0; mif.mem_rdata = '0;
        next_cycle();
        rst = 1'b0;
        #1;
        clear_model();
        check("rst_miss", miss, 0);
        check("rst_mem_req", mif.mem_req, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_addr_lo", addr_lo, 0);
        check("rst_load_type_q", load_type_q, 0);
        exp_rd = 32'h0; exp_lo = 2'b0; exp_lt = 3'b0;
    endtask

    task automatic do_read(input logic [31:0] a, input logic [2:0] lt, input int k);
        int s = set_of(a);
        bit h = model_hit(a);
        next_cycle();
        rd_req = 1'b1; wr_req = 1'b0; addr = a; load_type = lt; mif.mem_ack = 1'b0;
        #1;
        check("rd_miss_first", miss, 32'(!h));
        check("rd_req_first", mif.mem_req, 0);
        if (!h) begin
            check("rd_wb_hold_first", rd_data, exp_rd);
            for (int j = 0; j <= k; j++) begin
                next_cycle();
                mif.mem_ack   = (j == k);
                mif.mem_rdata = (j == k) ? mem_word(a) : $urandom;
                #1;
                check("fill_miss", miss, 1);
                check("fill_mem_req", mif.mem_req, 1);
                check("fill_mem_we", mif.mem_we, 0);
                check("fill_mem_addr", mif.mem_addr, {a[31:2], 2'b00});
                check("fill_wb_hold", rd_data, exp_rd);
            end
            next_cycle();
            mif.mem_ack = 1'b0;
            #1;
            m_valid[s] = 1'b1;
            m_word[s]  = a[31:2];
            m_data[s]  = mem_word(a);
            check("rehit_miss", miss, 0);
            check("rehit_mem_req", mif.mem_req, 0);
        end
        exp_rd = m_data[s]; exp_lo = a[1:0]; exp_lt = lt;
        next_cycle();
        idle_cycle();
        check("rd_data", rd_data, m_data[s]);
        check("rd_addr_lo", addr_lo, 32'(a[1:0]));
        check("rd_load_type_q", load_type_q, 32'(lt));
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                            input int k);
        int s = set_of(a);
        bit h = model_hit(a);
        logic [2:0] lt = lt_pool[$urandom_range(0, 5)];
        next_cycle();
        wr_req = 1'b1; rd_req = 1'b0; addr = a; wr_data = d; wr_be = be; load_type = lt;
        mif.mem_ack = 1'b0;
        #1;
        check("st_miss_first", miss, 1);
        check("st_req_first", mif.mem_req, 0);
        for (int j = 0; j <= k; j++) begin
            next_cycle();
            mif.mem_ack   = (j == k);
            mif.mem_rdata = $urandom;
            #1;
            check("write_miss", miss, 1);
            check("write_mem_req", mif.mem_req, 1);
            check("write_mem_we", mif.mem_we, 1);
            check("write_mem_addr", mif.mem_addr, {a[31:2], 2'b00});
            check("write_mem_wdata", mif.mem_wdata, d);
            check("write_mem_be", mif.mem_be, 32'(be));
            check("write_wb_hold", rd_data, exp_rd);
        end
        next_cycle();
        mif.mem_ack   = 1'($urandom_range(0, 1));
        mif.mem_rdata = $urandom;
        #1;
        mem_img[a[31:2]] = merge(mem_word(a), d, be);
        if (h) m_data[s] = merge(m_data[s], d, be);
        check("done_miss", miss, 0);
        check("done_mem_req", mif.mem_req, 0);
        exp_rd = 32'h0; exp_lo = a[1:0]; exp_lt = lt;
        next_cycle();
        idle_cycle();
        check("st_rd_data", rd_data, 0);
        check("st_addr_lo", addr_lo, 32'(a[1:0]));
        check("st_load_type_q", load_type_q, 32'(lt));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; rd_req = 1'b0; wr_req = 1'b0; addr = '0; wr_data = '0; wr_be = '0;
        load_type = '0; mif.mem_ack = 1'b0; mif.mem_rdata = '0;
        clear_model();
        do_reset();

        // Fill, re-read as a halfword, then write-through merge.
        mem_img[30'(32'h40 >> 2)] = 32'hDEADBEEF;
        do_read(32'h40, LW, 3);
        do_read(32'h42, LH, 0);
        do_store(32'h41, 32'h0000AA00, 4'b0010, 1);
        do_read(32'h40, LW, 0);

        // Store miss does not allocate.
        do_store(32'h80, 32'hCAFEF00D, 4'b1111, 2);
        do_read(32'h80, LW, 1);

        // Set conflict: 0xC0 evicts 0x40.
        do_reset();
        mem_img[30'(32'h40 >> 2)] = 32'h11111111;
        mem_img[30'(32'hC0 >> 2)] = 32'h22222222;
        do_read(32'h40, LW, 1);
        do_read(32'hC0, LW, 2);
        do_read(32'h40, LBU, 0);

        // Reset mid-fill with a late ack.
        next_cycle();
        rd_req = 1'b1; addr = 32'h100; load_type = LW;
        #1;
        check("rstfill_miss", miss, 1);
        next_cycle();
        #1;
        check("rstfill_mem_req", mif.mem_req, 1);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0; rd_req = 1'b0; load_type = '0;
        mif.mem_ack = 1'b1; mif.mem_rdata = 32'h0BAD0BAD;
        #1;
        clear_model();
        check("rstfill_req_low", mif.mem_req, 0);
        check("rstfill_miss_low", miss, 0);
        check("rstfill_rd_data", rd_data, 0);
        exp_rd = 32'h0; exp_lo = addr[1:0]; exp_lt = load_type;
        next_cycle();
        mif.mem_ack = 1'b0;
        #1;
        check("rstfill_late_ack", mif.mem_req, 0);
        mem_img[30'(32'h100 >> 2)] = 32'h12345678;
        do_read(32'h100, LW, 1);
        do_read(32'hC0, LW, 0);

        // Zero-latency acks.
        do_read(32'h200, LW, 0);
        do_store(32'h204, 32'h5A5A5A5A, 4'b1001, 0);
        do_store(32'h200, 32'h00FF0000, 4'b0100, 0);
        do_read(32'h200, LHU, 0);

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 1) == 1)
                do_read(rand_addr(), lt_pool[$urandom_range(0, 5)], $urandom_range(0, 3));
            else
                do_store(rand_addr(), $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
